// File: rtl/mem_arbiter.sv
// Arbitrates the shared byte-serial memory controller between instruction fetch and the LSB.
// LSB-first priority with a starvation override for fetch; ROB flush cancels fetches and loads only.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        rob_clear_up,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    output logic        if_ack,
    output logic [31:0] if_inst,
    output logic [31:0] if_inst_addr,
    input  logic        lsb_req,
    input  logic        lsb_is_store,
    input  logic [2:0]  lsb_op,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_ack,
    output logic [31:0] lsb_rdata,
    output logic        mc_fetch_start,
    output logic [31:0] mc_pc,
    output logic        mc_lsb_start,
    output logic        mc_is_store,
    output logic [2:0]  mc_op,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_wdata,
    input  logic        mc_fetch_done,
    input  logic [31:0] mc_inst,
    input  logic        mc_lsb_done,
    input  logic [31:0] mc_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_L, RESP} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic             grant_f, grant_l;
    logic             fetch_done, lsb_done;
    logic             if_ack_q, lsb_ack_q;

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        grant_f    = 1'b0;
        grant_l    = 1'b0;
        fetch_done = 1'b0;
        lsb_done   = 1'b0;
        case (state)
            IDLE: begin
                if (!rob_clear_up) begin
                    if (if_req && (!lsb_req || starve_cnt == LIMIT)) begin
                        grant_f = 1'b1;
                    end else if (lsb_req) begin
                        grant_l = 1'b1;
                    end
                end
                if (grant_f) begin
                    state_nxt  = BUSY_F;
                    starve_nxt = '0;
                end else if (grant_l) begin
                    state_nxt = BUSY_L;
                    if (!if_req) begin
                        starve_nxt = '0;
                    end else if (starve_cnt != LIMIT) begin
                        starve_nxt = starve_cnt + CNT_W'(1);
                    end
                end
            end
            BUSY_F: begin
                if (rob_clear_up) begin
                    state_nxt = IDLE;
                end else if (mc_fetch_done) begin
                    fetch_done = 1'b1;
                    state_nxt  = RESP;
                end
            end
            BUSY_L: begin
                // An in-flight store cannot be retracted, so the flush only squashes loads.
                if (rob_clear_up && !mc_is_store) begin
                    state_nxt = IDLE;
                end else if (mc_lsb_done) begin
                    lsb_done  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (rob_clear_up) begin
            starve_nxt = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            mc_pc        <= '0;
            mc_is_store  <= 1'b0;
            mc_op        <= '0;
            mc_addr      <= '0;
            mc_wdata     <= '0;
            if_inst      <= '0;
            if_inst_addr <= '0;
            lsb_rdata    <= '0;
            if_ack_q     <= 1'b0;
            lsb_ack_q    <= 1'b0;
        end else if (rdy_in) begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if_ack_q   <= fetch_done;
            lsb_ack_q  <= lsb_done;
            if (grant_f) begin
                mc_pc <= if_pc;
            end
            if (grant_l) begin
                mc_is_store <= lsb_is_store;
                mc_op       <= lsb_op;
                mc_addr     <= lsb_addr;
                mc_wdata    <= lsb_wdata;
            end
            if (fetch_done) begin
                if_inst      <= mc_inst;
                if_inst_addr <= mc_pc;
            end
            if (lsb_done) begin
                lsb_rdata <= mc_is_store ? 32'h0 : mc_rdata;
            end
        end
    end

    // A flush landing in the ack cycle still squashes fetch/load results; mc_is_store
    // is stable through RESP because no new grant happens before IDLE.
    assign if_ack         = if_ack_q & ~rob_clear_up;
    assign lsb_ack        = lsb_ack_q & ~(rob_clear_up & ~mc_is_store);
    assign mc_fetch_start = (state == BUSY_F);
    assign mc_lsb_start   = (state == BUSY_L);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with a queue of expected acks.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, rob_clear_up;
    logic        if_req;
    logic [31:0] if_pc;
    logic        if_ack;
    logic [31:0] if_inst, if_inst_addr;
    logic        lsb_req, lsb_is_store;
    logic [2:0]  lsb_op;
    logic [31:0] lsb_addr, lsb_wdata;
    logic        lsb_ack;
    logic [31:0] lsb_rdata;
    logic        mc_fetch_start, mc_lsb_start, mc_is_store;
    logic [31:0] mc_pc, mc_addr, mc_wdata;
    logic [2:0]  mc_op;
    logic        mc_fetch_done, mc_lsb_done;
    logic [31:0] mc_inst, mc_rdata;

    typedef struct {
        logic        is_fetch;
        logic [31:0] data;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    always #5 clk_in = ~clk_in;

    mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rob_clear_up(rob_clear_up),
        .if_req(if_req), .if_pc(if_pc), .if_ack(if_ack), .if_inst(if_inst),
        .if_inst_addr(if_inst_addr), .lsb_req(lsb_req), .lsb_is_store(lsb_is_store),
        .lsb_op(lsb_op), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_ack(lsb_ack),
        .lsb_rdata(lsb_rdata), .mc_fetch_start(mc_fetch_start), .mc_pc(mc_pc),
        .mc_lsb_start(mc_lsb_start), .mc_is_store(mc_is_store), .mc_op(mc_op),
        .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_fetch_done(mc_fetch_done),
        .mc_inst(mc_inst), .mc_lsb_done(mc_lsb_done), .mc_rdata(mc_rdata)
    );

    // Advance past the next active edge; sampling and driving both happen 1ns after it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        step();
        step();
        checks++;
        if ({mc_fetch_start, mc_lsb_start, if_ack, lsb_ack} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000", {mc_fetch_start, mc_lsb_start, if_ack, lsb_ack});
        end
        checks++;
        if ({mc_pc, mc_addr, mc_wdata, mc_op, mc_is_store} !== 100'b0) begin
            errors++;
            $display("FAIL reset_cmd: got pc=%h addr=%h wdata=%h want 0", mc_pc, mc_addr, mc_wdata);
        end
        checks++;
        if ({if_inst, if_inst_addr, lsb_rdata} !== 96'b0) begin
            errors++;
            $display("FAIL reset_result: got inst=%h iaddr=%h rdata=%h want 0", if_inst, if_inst_addr, lsb_rdata);
        end
        rst_n_in = 1'b1;
        step();
        checks++;
        if ({mc_fetch_start, mc_lsb_start} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: got starts=%b want 00", {mc_fetch_start, mc_lsb_start});
        end
    endtask

    task automatic test_lone_fetch();
        if_req = 1'b1;
        if_pc  = 32'h100;
        step();
        checks++;
        if (mc_fetch_start !== 1'b1 || mc_lsb_start !== 1'b0 || mc_pc !== 32'h100) begin
            errors++;
            $display("FAIL lone_grant: got fs=%b ls=%b pc=%h want 1 0 00000100", mc_fetch_start, mc_lsb_start, mc_pc);
        end
        sb.push_back('{1'b1, 32'h00500093, 32'h100});
        step();
        step();
        step();
        checks++;
        if (mc_fetch_start !== 1'b1 || mc_pc !== 32'h100 || if_ack !== 1'b0) begin
            errors++;
            $display("FAIL lone_hold: got fs=%b pc=%h ack=%b want 1 00000100 0", mc_fetch_start, mc_pc, if_ack);
        end
        mc_fetch_done = 1'b1;
        mc_inst       = 32'h00500093;
        step();
        mc_fetch_done = 1'b0;
        mc_inst       = 32'h0;
        checks++;
        if (if_ack !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL lone_ack: got ack=%b queued=%0d want 1", if_ack, sb.size());
        end else begin
            e = sb.pop_front();
            checks++;
            if (!e.is_fetch || if_inst !== e.data || if_inst_addr !== e.addr) begin
                errors++;
                $display("FAIL lone_data: got inst=%h addr=%h want %h %h", if_inst, if_inst_addr, e.data, e.addr);
            end
        end
        if_req = 1'b0;
        checks++;
        if (mc_fetch_start !== 1'b0) begin
            errors++;
            $display("FAIL lone_start_drop: got %b want 0", mc_fetch_start);
        end
        step();
        checks++;
        if (if_ack !== 1'b0 || mc_fetch_start !== 1'b0) begin
            errors++;
            $display("FAIL lone_after: got ack=%b fs=%b want 0 0", if_ack, mc_fetch_start);
        end
    endtask

    task automatic test_contention();
        if_req       = 1'b1;
        if_pc        = 32'h200;
        lsb_req      = 1'b1;
        lsb_is_store = 1'b0;
        lsb_op       = 3'b010;
        lsb_addr     = 32'h20;
        lsb_wdata    = 32'h0;
        step();
        checks++;
        if (mc_lsb_start !== 1'b1 || mc_fetch_start !== 1'b0 || mc_addr !== 32'h20 ||
            mc_op !== 3'b010 || mc_is_store !== 1'b0) begin
            errors++;
            $display("FAIL cont_lsb_grant: got ls=%b fs=%b addr=%h op=%b st=%b want 1 0 20 010 0",
                     mc_lsb_start, mc_fetch_start, mc_addr, mc_op, mc_is_store);
        end
        sb.push_back('{1'b0, 32'hDEADBEEF, 32'h20});
        mc_lsb_done = 1'b1;
        mc_rdata    = 32'hDEADBEEF;
        step();
        mc_lsb_done = 1'b0;
        checks++;
        if (lsb_ack !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL cont_lsb_ack: got ack=%b want 1", lsb_ack);
        end else begin
            e = sb.pop_front();
            checks++;
            if (e.is_fetch || lsb_rdata !== e.data) begin
                errors++;
                $display("FAIL cont_lsb_data: got %h want %h", lsb_rdata, e.data);
            end
        end
        lsb_req = 1'b0;
        step();
        checks++;
        if (mc_fetch_start !== 1'b0 || lsb_ack !== 1'b0) begin
            errors++;
            $display("FAIL cont_gap: got fs=%b ack=%b want 0 0", mc_fetch_start, lsb_ack);
        end
        step();
        checks++;
        if (mc_fetch_start !== 1'b1 || mc_pc !== 32'h200) begin
            errors++;
            $display("FAIL cont_fetch_grant: got fs=%b pc=%h want 1 00000200", mc_fetch_start, mc_pc);
        end
        sb.push_back('{1'b1, 32'h12345678, 32'h200});
        mc_fetch_done = 1'b1;
        mc_inst       = 32'h12345678;
        step();
        mc_fetch_done = 1'b0;
        checks++;
        if (if_ack !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL cont_fetch_ack: got %b want 1", if_ack);
        end else begin
            e = sb.pop_front();
            checks++;
            if (if_inst !== e.data || if_inst_addr !== e.addr) begin
                errors++;
                $display("FAIL cont_fetch_data: got %h@%h want %h@%h", if_inst, if_inst_addr, e.data, e.addr);
            end
        end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        int lsb_grants = 0;
        if_req       = 1'b1;
        if_pc        = 32'h300;
        lsb_req      = 1'b1;
        lsb_is_store = 1'b0;
        lsb_op       = 3'b000;
        for (int i = 0; i < 4; i++) begin
            lsb_addr = 32'h40 + 32'(4 * i);
            step();
            if (mc_lsb_start === 1'b1 && mc_fetch_start === 1'b0) lsb_grants++;
            sb.push_back('{1'b0, 32'h1000 + 32'(i), lsb_addr});
            mc_lsb_done = 1'b1;
            mc_rdata    = 32'h1000 + 32'(i);
            step();
            mc_lsb_done = 1'b0;
            checks++;
            if (lsb_ack !== 1'b1 || sb.size() == 0) begin
                errors++;
                $display("FAIL starve_ack%0d: got %b want 1", i, lsb_ack);
            end else begin
                e = sb.pop_front();
                if (lsb_rdata !== e.data) begin
                    errors++;
                    $display("FAIL starve_data%0d: got %h want %h", i, lsb_rdata, e.data);
                end
            end
            step();
        end
        checks++;
        if (lsb_grants !== 4) begin
            errors++;
            $display("FAIL starve_lsb_count: got %0d want 4", lsb_grants);
        end
        step();
        checks++;
        if (mc_fetch_start !== 1'b1 || mc_lsb_start !== 1'b0 || mc_pc !== 32'h300) begin
            errors++;
            $display("FAIL starve_fetch_wins: got fs=%b ls=%b pc=%h want 1 0 00000300", mc_fetch_start, mc_lsb_start, mc_pc);
        end
        sb.push_back('{1'b1, 32'hABCDEF01, 32'h300});
        mc_fetch_done = 1'b1;
        mc_inst       = 32'hABCDEF01;
        step();
        mc_fetch_done = 1'b0;
        checks++;
        if (if_ack !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL starve_fetch_ack: got %b want 1", if_ack);
        end else begin
            e = sb.pop_front();
            if (if_inst !== e.data || if_inst_addr !== e.addr) begin
                errors++;
                $display("FAIL starve_fetch_data: got %h@%h want %h@%h", if_inst, if_inst_addr, e.data, e.addr);
            end
        end
        if_pc = 32'h304;
        step();
        step();
        // Counter was cleared by the fetch grant, so the next contested round goes to the LSB.
        checks++;
        if (mc_lsb_start !== 1'b1 || mc_fetch_start !== 1'b0) begin
            errors++;
            $display("FAIL starve_cnt_cleared: got ls=%b fs=%b want 1 0", mc_lsb_start, mc_fetch_start);
        end
        if_req = 1'b0;
        sb.push_back('{1'b0, 32'h2222, lsb_addr});
        mc_lsb_done = 1'b1;
        mc_rdata    = 32'h2222;
        step();
        mc_lsb_done = 1'b0;
        checks++;
        if (lsb_ack !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL starve_last_ack: got %b want 1", lsb_ack);
        end else begin
            e = sb.pop_front();
            if (lsb_rdata !== e.data) begin
                errors++;
                $display("FAIL starve_last_data: got %h want %h", lsb_rdata, e.data);
            end
        end
        lsb_req = 1'b0;
        step();
    endtask

    task automatic test_flush_load();
        int late_acks = 0;
        lsb_req      = 1'b1;
        lsb_is_store = 1'b0;
        lsb_op       = 3'b100;
        lsb_addr     = 32'h44;
        step();
        checks++;
        if (mc_lsb_start !== 1'b1) begin
            errors++;
            $display("FAIL fl_load_grant: got %b want 1", mc_lsb_start);
        end
        step();
        rob_clear_up = 1'b1;
        lsb_req      = 1'b0;
        step();
        rob_clear_up = 1'b0;
        checks++;
        if (mc_lsb_start !== 1'b0 || lsb_ack !== 1'b0) begin
            errors++;
            $display("FAIL fl_load_cancel: got ls=%b ack=%b want 0 0", mc_lsb_start, lsb_ack);
        end
        mc_lsb_done = 1'b1;
        mc_rdata    = 32'h77777777;
        step();
        mc_lsb_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (lsb_ack !== 1'b0 || mc_lsb_start !== 1'b0) late_acks++;
            step();
        end
        checks++;
        if (late_acks !== 0) begin
            errors++;
            $display("FAIL fl_load_late_done: got %0d bad cycles want 0", late_acks);
        end
        checks++;
        if (lsb_rdata !== 32'h2222) begin
            errors++;
            $display("FAIL fl_load_rdata_kept: got %h want 00002222", lsb_rdata);
        end
    endtask

    task automatic test_flush_store();
        lsb_req      = 1'b1;
        lsb_is_store = 1'b1;
        lsb_op       = 3'b010;
        lsb_addr     = 32'h30000;
        lsb_wdata    = 32'hCAFEF00D;
        step();
        checks++;
        if (mc_lsb_start !== 1'b1 || mc_is_store !== 1'b1 || mc_addr !== 32'h30000 || mc_wdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL fl_store_grant: got ls=%b st=%b addr=%h wd=%h want 1 1 00030000 cafef00d",
                     mc_lsb_start, mc_is_store, mc_addr, mc_wdata);
        end
        sb.push_back('{1'b0, 32'h0, 32'h30000});
        rob_clear_up = 1'b1;
        step();
        rob_clear_up = 1'b0;
        step();
        checks++;
        if (mc_lsb_start !== 1'b1 || mc_addr !== 32'h30000) begin
            errors++;
            $display("FAIL fl_store_kept: got ls=%b addr=%h want 1 00030000", mc_lsb_start, mc_addr);
        end
        mc_lsb_done = 1'b1;
        mc_rdata    = 32'h55555555;
        step();
        mc_lsb_done = 1'b0;
        checks++;
        if (lsb_ack !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL fl_store_ack: got %b want 1", lsb_ack);
        end else begin
            e = sb.pop_front();
            checks++;
            if (lsb_rdata !== e.data) begin
                errors++;
                $display("FAIL fl_store_rdata: got %h want %h", lsb_rdata, e.data);
            end
        end
        lsb_req = 1'b0;
        step();
        checks++;
        if (lsb_ack !== 1'b0 || mc_lsb_start !== 1'b0) begin
            errors++;
            $display("FAIL fl_store_after: got ack=%b ls=%b want 0 0", lsb_ack, mc_lsb_start);
        end
    endtask

    task automatic test_stall_reset();
        int bad = 0;
        if_req = 1'b1;
        if_pc  = 32'h400;
        step();
        checks++;
        if (mc_fetch_start !== 1'b1 || mc_pc !== 32'h400) begin
            errors++;
            $display("FAIL stall_grant: got fs=%b pc=%h want 1 00000400", mc_fetch_start, mc_pc);
        end
        rdy_in        = 1'b0;
        mc_fetch_done = 1'b1;
        mc_inst       = 32'h99999999;
        if_pc         = 32'h500;
        for (int i = 0; i < 3; i++) begin
            step();
            if (mc_fetch_start !== 1'b1 || mc_lsb_start !== 1'b0 || mc_pc !== 32'h400 ||
                if_ack !== 1'b0 || mc_addr !== 32'h30000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_frozen: got %0d bad cycles want 0", bad);
        end
        mc_fetch_done = 1'b0;
        rst_n_in      = 1'b0;
        step();
        rst_n_in = 1'b1;
        rdy_in   = 1'b1;
        if_req   = 1'b0;
        checks++;
        if ({mc_fetch_start, mc_lsb_start, if_ack, lsb_ack, mc_is_store} !== 5'b0 ||
            {mc_pc, mc_addr, mc_wdata, mc_op} !== 99'b0) begin
            errors++;
            $display("FAIL stall_reset_cmd: got fs=%b pc=%h addr=%h wd=%h want all 0", mc_fetch_start, mc_pc, mc_addr, mc_wdata);
        end
        checks++;
        if ({if_inst, if_inst_addr, lsb_rdata} !== 96'b0) begin
            errors++;
            $display("FAIL stall_reset_result: got inst=%h ia=%h rd=%h want 0", if_inst, if_inst_addr, lsb_rdata);
        end
        step();
        checks++;
        if ({mc_fetch_start, mc_lsb_start, if_ack} !== 3'b0) begin
            errors++;
            $display("FAIL stall_reset_idle: got %b want 000", {mc_fetch_start, mc_lsb_start, if_ack});
        end
    endtask

    always @(negedge clk_in) begin
        if (mc_fetch_start === 1'b1 && mc_lsb_start === 1'b1) begin
            errors++;
            $display("FAIL both_starts: got fs=1 ls=1 want exclusive");
        end
    end

    initial begin
        rst_n_in      = 1'b0;
        rdy_in        = 1'b1;
        rob_clear_up  = 1'b0;
        if_req        = 1'b0;
        if_pc         = 32'h0;
        lsb_req       = 1'b0;
        lsb_is_store  = 1'b0;
        lsb_op        = 3'b0;
        lsb_addr      = 32'h0;
        lsb_wdata     = 32'h0;
        mc_fetch_done = 1'b0;
        mc_inst       = 32'h0;
        mc_lsb_done   = 1'b0;
        mc_rdata      = 32'h0;
        test_reset();
        test_lone_fetch();
        test_contention();
        test_starvation();
        test_flush_load();
        test_flush_store();
        test_stall_reset();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
